// File: rtl/hazard_stall_unit_pkg.sv
// Shared decode constants and FSM state type for the hazard/stall unit
// and the source-register decoder.
package hazard_stall_unit_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  function automatic logic is_multdiv(input logic [4:0] opc, input logic [4:0] alu);
    return (opc == OP_R) && ((alu == ALU_MUL) || (alu == ALU_DIV));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_src_reg_decode.sv
// Source-register decoder for the D-stage instruction; r0 sources are
// reported as invalid so they can never produce a dependency.
module src_reg_decode
  import hazard_stall_unit_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [4:0]  src_a_o,
  output logic        src_a_vld_o,
  output logic [4:0]  src_b_o,
  output logic        src_b_vld_o
);

  logic [4:0] opc;
  logic [4:0] rd;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] a;
  logic [4:0] b;
  logic       a_used;
  logic       b_used;
  logic       unused_ir;

  assign opc       = ir_i[OPC_HI:OPC_LO];
  assign rd        = ir_i[RD_HI:RD_LO];
  assign rs        = ir_i[RS_HI:RS_LO];
  assign rt        = ir_i[RT_HI:RT_LO];
  assign unused_ir = ^ir_i[11:0];

  // sw store data (Rd) is deliberately not a source: W->M bypass covers it.
  always_comb begin
    a      = '0;
    b      = '0;
    a_used = 1'b0;
    b_used = 1'b0;
    case (opc)
      OP_R: begin
        a      = rs;
        b      = rt;
        a_used = 1'b1;
        b_used = 1'b1;
      end
      OP_ADDI, OP_LW, OP_SW: begin
        a      = rs;
        a_used = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        a      = rd;
        b      = rs;
        a_used = 1'b1;
        b_used = 1'b1;
      end
      OP_JR: begin
        a      = rd;
        a_used = 1'b1;
      end
      OP_BEX: begin
        a      = REG_STATUS;
        a_used = 1'b1;
      end
      default: begin
        a_used = 1'b0;
        b_used = 1'b0;
      end
    endcase
  end

  assign src_a_o     = a;
  assign src_b_o     = b;
  assign src_a_vld_o = a_used && (a != '0);
  assign src_b_vld_o = b_used && (b != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use stall, multdiv occupancy FSM and branch flush.
// Optional multdiv watchdog enabled by defining HAZ_TIMEOUT_EN.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      IR_D,
  input  logic [31:0]      IR_X,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             md_start,
  output logic             md_is_div,
  output logic             stall_PC,
  output logic             stall_FD,
  output logic             stall_DX,
  output logic             nop_DX,
  output logic             nop_XM,
  output logic             flush_FD,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             md_error
);

  md_state_t        state_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [4:0] x_opc;
  logic [4:0] x_rd;
  logic [4:0] x_alu;
  logic       x_is_lw;
  logic       x_is_md;
  logic       unused_irx;

  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       src_a_vld;
  logic       src_b_vld;

  logic load_use;
  logic md_timeout;
  logic md_start_c;
  logic md_busy;
  logic md_hold;
  logic flush;

  assign x_opc      = IR_X[OPC_HI:OPC_LO];
  assign x_rd       = IR_X[RD_HI:RD_LO];
  assign x_alu      = IR_X[ALU_HI:ALU_LO];
  assign x_is_lw    = (x_opc == OP_LW);
  assign x_is_md    = is_multdiv(x_opc, x_alu);
  assign unused_irx = ^{IR_X[21:7], IR_X[1:0]};

  src_reg_decode u_src_dec (
    .ir_i        (IR_D),
    .src_a_o     (src_a),
    .src_a_vld_o (src_a_vld),
    .src_b_o     (src_b),
    .src_b_vld_o (src_b_vld)
  );

  assign load_use = x_is_lw && (x_rd != '0) &&
                    ((src_a_vld && (src_a == x_rd)) || (src_b_vld && (src_b == x_rd)));

`ifdef HAZ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(MD_TIMEOUT + 1);

  logic [TO_W-1:0] md_cnt_q;
  logic            md_err_q;

  assign md_timeout = (state_q == MD_BUSY) && !md_ready &&
                      (md_cnt_q == TO_W'(MD_TIMEOUT - 1));

  // Counter sits at zero outside BUSY, which gives the clear-on-entry behaviour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q <= '0;
      md_err_q <= 1'b0;
    end else begin
      if (state_q == MD_BUSY && !md_timeout) begin
        md_cnt_q <= md_cnt_q + TO_W'(1);
      end else begin
        md_cnt_q <= '0;
      end
      if (md_timeout) begin
        md_err_q <= 1'b1;
      end
    end
  end

  assign md_error = md_err_q;
`else
  logic unused_timeout;

  assign md_timeout     = 1'b0;
  assign md_error       = 1'b0;
  assign unused_timeout = (MD_TIMEOUT == 0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (x_is_md) state_q <= MD_BUSY;
        MD_BUSY: if (md_ready || md_timeout) state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // Outputs are combinational so stalls take effect in the detecting cycle;
  // every control is gated by reset_n so nothing acts during reset.
  always_comb begin
    md_start_c = (state_q == MD_IDLE) && x_is_md;
    md_busy    = (state_q == MD_BUSY) || md_start_c;
    md_hold    = md_start_c || ((state_q == MD_BUSY) && !md_ready && !md_timeout);
    flush      = branch_taken && !md_busy;

    md_start   = reset_n && md_start_c;
    md_is_div  = reset_n && md_start_c && (x_alu == ALU_DIV);
    stall_PC   = reset_n && (md_hold || (load_use && !flush));
    stall_FD   = reset_n && (md_hold || (load_use && !flush));
    stall_DX   = reset_n && md_hold;
    nop_DX     = reset_n && !md_hold && (load_use || flush);
    nop_XM     = reset_n && (md_hold || md_timeout);
    flush_FD   = reset_n && flush;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall_PC && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit.
module tb_hazard_stall_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] IR_D;
  logic [31:0] IR_X;
  logic        branch_taken;
  logic        md_ready;
  logic        md_start;
  logic        md_is_div;
  logic        stall_PC;
  logic        stall_FD;
  logic        stall_DX;
  logic        nop_DX;
  logic        nop_XM;
  logic        flush_FD;
  logic [31:0] stall_cycles;
  logic        md_error;

  logic [7:0]  ctl;
  int unsigned vectors;
  int unsigned miscompares;
  int unsigned exp_stalls;

  hazard_stall_unit #(.MD_TIMEOUT(8), .CNT_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .IR_D         (IR_D),
    .IR_X         (IR_X),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .stall_PC     (stall_PC),
    .stall_FD     (stall_FD),
    .stall_DX     (stall_DX),
    .nop_DX       (nop_DX),
    .nop_XM       (nop_XM),
    .flush_FD     (flush_FD),
    .stall_cycles (stall_cycles),
    .md_error     (md_error)
  );

  // {md_start, md_is_div, stall_PC, stall_FD, stall_DX, nop_DX, nop_XM, flush_FD}
  assign ctl = {md_start, md_is_div, stall_PC, stall_FD, stall_DX, nop_DX, nop_XM, flush_FD};

  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_LU    = 8'h34;
  localparam logic [7:0] C_MUL0  = 8'hBA;
  localparam logic [7:0] C_DIV0  = 8'hFA;
  localparam logic [7:0] C_BUSY  = 8'h3A;
  localparam logic [7:0] C_FLUSH = 8'h05;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input logic [4:0] alu, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    IR_X         = enc_r(5'b00110, 5'd4, 5'd2, 5'd3);
    IR_D         = enc_r(5'b00000, 5'd6, 5'd4, 5'd1);
    branch_taken = 1'b1;
    md_ready     = 1'b0;
    #2;
    vectors++;
    if (ctl !== C_NONE) begin
      miscompares++;
      $display("FAIL reset_ctl: got %h want %h", ctl, C_NONE);
    end
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (ctl !== C_NONE || stall_cycles !== 32'd0 || md_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: ctl %h cnt %0d err %b want 00/0/0", ctl, stall_cycles, md_error);
    end
    IR_X         = '0;
    IR_D         = '0;
    branch_taken = 1'b0;
    reset_n      = 1'b1;
    tick();
    exp_stalls = 0;
    vectors++;
    if (ctl !== C_NONE || stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_release: ctl %h cnt %0d want 00/0", ctl, stall_cycles);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] tx[12];
    logic [31:0] td[12];
    logic        ts[12];
    tx[0]  = enc_i(5'b01000, 5'd5,  5'd2, 17'd0); td[0]  = enc_r(5'b00000, 5'd6, 5'd5, 5'd1); ts[0]  = 1'b1;
    tx[1]  = enc_i(5'b01000, 5'd5,  5'd2, 17'd0); td[1]  = enc_r(5'b00000, 5'd6, 5'd1, 5'd5); ts[1]  = 1'b1;
    tx[2]  = enc_i(5'b01000, 5'd5,  5'd2, 17'd0); td[2]  = enc_i(5'b00111, 5'd5, 5'd3, 17'd0); ts[2]  = 1'b0;
    tx[3]  = enc_i(5'b01000, 5'd3,  5'd2, 17'd0); td[3]  = enc_i(5'b00111, 5'd5, 5'd3, 17'd0); ts[3]  = 1'b1;
    tx[4]  = enc_i(5'b01000, 5'd0,  5'd2, 17'd0); td[4]  = enc_r(5'b00000, 5'd1, 5'd0, 5'd0); ts[4]  = 1'b0;
    tx[5]  = enc_i(5'b01000, 5'd7,  5'd2, 17'd0); td[5]  = enc_i(5'b00010, 5'd7, 5'd1, 17'd4); ts[5]  = 1'b1;
    tx[6]  = enc_i(5'b01000, 5'd9,  5'd2, 17'd0); td[6]  = enc_i(5'b00100, 5'd9, 5'd0, 17'd0); ts[6]  = 1'b1;
    tx[7]  = enc_i(5'b01000, 5'd30, 5'd2, 17'd0); td[7]  = enc_i(5'b10110, 5'd0, 5'd0, 17'd8); ts[7]  = 1'b1;
    tx[8]  = enc_i(5'b01000, 5'd5,  5'd2, 17'd0); td[8]  = enc_i(5'b00101, 5'd5, 5'd6, 17'd4); ts[8]  = 1'b0;
    tx[9]  = enc_r(5'b00000, 5'd5,  5'd2, 5'd3);  td[9]  = enc_r(5'b00000, 5'd6, 5'd5, 5'd1); ts[9]  = 1'b0;
    tx[10] = enc_i(5'b01000, 5'd12, 5'd2, 17'd0); td[10] = enc_i(5'b00110, 5'd1, 5'd12, 17'd4); ts[10] = 1'b1;
    tx[11] = enc_i(5'b01000, 5'd4,  5'd2, 17'd0); td[11] = enc_i(5'b00011, 5'd4, 5'd4, 17'd0); ts[11] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      IR_X = tx[i];
      IR_D = td[i];
      @(negedge clock);
      vectors++;
      if (ctl !== (ts[i] ? C_LU : C_NONE)) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got %h want %h", i, ctl, ts[i] ? C_LU : C_NONE);
      end
      if (ts[i]) exp_stalls++;
      tick();
      // Bubble reaches X after a load-use stall; hazard must be gone.
      IR_X = '0;
      @(negedge clock);
      vectors++;
      if (ctl !== C_NONE) begin
        miscompares++;
        $display("FAIL load_use_clear[%0d]: got %h want 00", i, ctl);
      end
      tick();
    end
    vectors++;
    if (stall_cycles !== exp_stalls) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d want %0d", stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_multdiv();
    logic [7:0] exp;
    IR_X = enc_r(5'b00110, 5'd4, 5'd2, 5'd3);
    IR_D = enc_r(5'b00000, 5'd6, 5'd4, 5'd1);
    for (int i = 0; i < 6; i++) begin
      md_ready     = (i == 5);
      branch_taken = (i == 2);
      exp = (i == 0) ? C_MUL0 : (i < 5) ? C_BUSY : C_NONE;
      @(negedge clock);
      vectors++;
      if (ctl !== exp) begin
        miscompares++;
        $display("FAIL multdiv[%0d]: got %h want %h", i, ctl, exp);
      end
      tick();
    end
    exp_stalls += 5;
    IR_X = '0;
    md_ready = 1'b0;
    branch_taken = 1'b0;
    @(negedge clock);
    vectors++;
    if (ctl !== C_NONE || stall_cycles !== exp_stalls) begin
      miscompares++;
      $display("FAIL multdiv_done: ctl %h cnt %0d want 00/%0d", ctl, stall_cycles, exp_stalls);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq_x[5];
    logic        seq_r[5];
    logic [7:0]  seq_e[5];
    seq_x[0] = enc_r(5'b00111, 5'd1, 5'd2, 5'd3); seq_r[0] = 1'b0; seq_e[0] = C_DIV0;
    seq_x[1] = enc_r(5'b00111, 5'd1, 5'd2, 5'd3); seq_r[1] = 1'b1; seq_e[1] = C_NONE;
    seq_x[2] = enc_r(5'b00110, 5'd7, 5'd1, 5'd1); seq_r[2] = 1'b0; seq_e[2] = C_MUL0;
    seq_x[3] = enc_r(5'b00110, 5'd7, 5'd1, 5'd1); seq_r[3] = 1'b1; seq_e[3] = C_NONE;
    seq_x[4] = '0;                                seq_r[4] = 1'b0; seq_e[4] = C_NONE;
    IR_D = '0;
    for (int i = 0; i < 5; i++) begin
      IR_X     = seq_x[i];
      md_ready = seq_r[i];
      @(negedge clock);
      vectors++;
      if (ctl !== seq_e[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, ctl, seq_e[i]);
      end
      tick();
    end
    md_ready = 1'b0;
    exp_stalls += 2;
    vectors++;
    if (stall_cycles !== exp_stalls) begin
      miscompares++;
      $display("FAIL back_to_back_count: got %0d want %0d", stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_flush();
    IR_X = enc_i(5'b01000, 5'd5, 5'd2, 17'd0);
    IR_D = enc_r(5'b00000, 5'd6, 5'd5, 5'd1);
    branch_taken = 1'b1;
    @(negedge clock);
    vectors++;
    if (ctl !== C_FLUSH) begin
      miscompares++;
      $display("FAIL flush_load_use: got %h want %h", ctl, C_FLUSH);
    end
    tick();
    IR_X = enc_r(5'b00000, 5'd5, 5'd2, 5'd3);
    @(negedge clock);
    vectors++;
    if (ctl !== C_FLUSH) begin
      miscompares++;
      $display("FAIL flush_plain: got %h want %h", ctl, C_FLUSH);
    end
    tick();
    branch_taken = 1'b0;
    IR_X = '0;
    vectors++;
    if (stall_cycles !== exp_stalls) begin
      miscompares++;
      $display("FAIL flush_count: got %0d want %0d", stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_reset_mid_busy();
    IR_X = enc_r(5'b00110, 5'd4, 5'd2, 5'd3);
    IR_D = '0;
    @(negedge clock);
    vectors++;
    if (ctl !== C_MUL0) begin
      miscompares++;
      $display("FAIL rst_busy_start: got %h want %h", ctl, C_MUL0);
    end
    tick();
    tick();
    reset_n = 1'b0;
    #2;
    exp_stalls = 0;
    vectors++;
    if (ctl !== C_NONE || stall_cycles !== 32'd0 || md_error !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy_async: ctl %h cnt %0d err %b want 00/0/0", ctl, stall_cycles, md_error);
    end
    @(negedge clock);
    IR_X = '0;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (ctl !== C_NONE) begin
        miscompares++;
        $display("FAIL rst_busy_after[%0d]: got %h want 00", i, ctl);
      end
      tick();
    end
  endtask

`ifdef HAZ_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] exp;
    IR_X = enc_r(5'b00110, 5'd4, 5'd2, 5'd3);
    IR_D = '0;
    md_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp = (i == 0) ? C_MUL0 : (i < 8) ? C_BUSY : 8'h02;
      @(negedge clock);
      vectors++;
      if (ctl !== exp) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got %h want %h", i, ctl, exp);
      end
      tick();
    end
    exp_stalls += 8;
    IR_X = '0;
    @(negedge clock);
    vectors++;
    if (ctl !== C_NONE || md_error !== 1'b1 || stall_cycles !== exp_stalls) begin
      miscompares++;
      $display("FAIL timeout_err: ctl %h err %b cnt %0d want 00/1/%0d", ctl, md_error, stall_cycles, exp_stalls);
    end
    tick();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_stalls  = 0;
    test_reset();
    test_load_use();
    test_multdiv();
    test_back_to_back();
    test_flush();
    test_reset_mid_busy();
`ifdef HAZ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Consumer-side counterpart to the pipeline forwarding logic. Detects the hazards that forwarding cannot cover and drives the pipeline latches.
  - Load-use interlock: freezes F/D and inserts a bubble into DX.
  - Multdiv occupancy: a small FSM starts the multdiv unit and holds F/D/X until the result is ready.
  - Branch/jump flush: squashes FD and DX.
- Sits beside the bypass network and drives the enable/nop-select controls of the PC, FD, DX and XM latches.

Parameters:
- MD_TIMEOUT, 64, multdiv watchdog limit in cycles (used only with HAZ_TIMEOUT_EN).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IR_D  in  32  instruction in the FD latch (decode).
- IR_X  in  32  instruction in the DX latch (execute).
- branch_taken  in  1  X-stage branch/jump redirect (bne/blt taken, j, jal, jr, bex taken).
- md_ready  in  1  multdiv result valid, 1-cycle pulse.
- md_start  out  1  1-cycle pulse that starts mult or div.
- md_is_div  out  1  qualifies md_start: 1 means div, 0 means mult.
- stall_PC  out  1  hold PC.
- stall_FD  out  1  hold FD latch.
- stall_DX  out  1  hold DX latch.
- nop_DX  out  1  load nop into DX.
- nop_XM  out  1  load nop into XM.
- flush_FD  out  1  load nop into FD.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_PC=1.
- md_error  out  1  sticky watchdog flag (tied 0 without the feature).

Behaviour:
- Decode fields:
  - opcode [31:27], Rd [26:22], Rs [21:17], Rt [16:12], ALU op [6:2].
  - Opcodes: lw=01000, sw=00111, addi=00101, R=00000, bne=00010, blt=00110, jr=00100, bex=10110.
  - mul is R with ALU op 00110; div is R with ALU op 00111.
- D-stage source registers:
  - R: Rs, Rt.
  - addi/lw: Rs.
  - sw: Rs only. The store-data Rd is covered by the W->M bypass, so it never stalls.
  - bne/blt: Rd, Rs.
  - jr: Rd.
  - bex: r30.
  - All others: none.
  - r0 never matches.
- Load-use: load_use = (IR_X is lw) & (IR_X.Rd != 0) & (IR_X.Rd matches any D source). It is combinational, with no added latency.
  - Effect: stall_PC=stall_FD=1 and nop_DX=1 for exactly one cycle. The next cycle, the lw is in M and the hazard clears naturally.
- Multdiv FSM states:
  - IDLE:
    - If IR_X is mul/div: md_start=1, md_is_div set, stall_PC=stall_FD=stall_DX=1, nop_XM=1; next state BUSY.
  - BUSY:
    - Same stalls and nop_XM while md_ready=0.
    - On md_ready=1: all stalls drop that cycle, nop_XM=0 so the result enters XM with the mul/div; next state IDLE.
  - Back-to-back mul/div: the second one starts in IDLE the cycle after release. md_start is never re-asserted for the same instruction.
- Flush: branch_taken=1 gives flush_FD=1 and nop_DX=1 in the same cycle.
  - Flush overrides load_use: stall_PC/stall_FD are forced 0, since the squashed D instruction must not hold the PC.
  - branch_taken is ignored while the FSM is in BUSY or is starting. It cannot occur then because X holds the mul/div.
- Priority:
  - Multdiv stall beats load_use, which beats no action.
  - When the multdiv stall is active, load_use outputs are masked. nop_DX=0 because DX is held.
- stall_cycles increments on every cycle with stall_PC=1 and saturates at all-ones.
- Reset, asynchronous while reset_n=0:
  - State goes to IDLE; stall_cycles=0; md_error=0.
  - All outputs are forced to 0 regardless of IR inputs.
  - Reset during BUSY abandons the operation. No md_start is issued after release until a new mul/div reaches X.

Optional Feature:
- Macro HAZ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY and clears on entry to BUSY.
  - If it reaches MD_TIMEOUT with no md_ready: md_error=1 (sticky until reset), the FSM returns to IDLE, stalls release, and nop_XM=1 for that cycle so no garbage result is written.
- Undefined: no counter; md_error tied 0; BUSY waits indefinitely.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_LW, OP_SW, OP_R, OP_ADDI, OP_BNE, OP_BLT, OP_JR, OP_BEX).
  - ALU op constants ALU_MUL, ALU_DIV.
  - Field-position constants.
  - FSM state typedef md_state_t {MD_IDLE, MD_BUSY}.
- One natural sub-module, src_reg_decode: IR_D in, src_a/src_b/valid flags out. It is reusable by the bypass path.

Test Plan:
- Load-use: IR_X=lw r5,0(r2); IR_D=add r6,r5,r1 -> one cycle of stall_PC=stall_FD=nop_DX=1, then 0; stall_cycles=1.
- Store-data exemption and r0: IR_X=lw r5; IR_D=sw r5,0(r3) -> no stall. IR_X=lw r0; IR_D=add r1,r0,r0 -> no stall.
- Multdiv: IR_X=mul r4,r2,r3; md_ready pulses 4 cycles later.
  - md_start=1 for one cycle, md_is_div=0.
  - Stalls and nop_XM held for 5 cycles, released in the md_ready cycle.
  - stall_cycles=5.
- Back-to-back: div then mul in X -> two distinct md_start pulses, md_is_div=1 then 0, none duplicated.
- Flush plus load_use: branch_taken=1 with load_use true -> flush_FD=nop_DX=1 and stall_PC=0.
- Reset mid-BUSY: reset_n low at BUSY cycle 2 -> all outputs 0 immediately; after release with IR_X=nop, no md_start.
- HAZ_TIMEOUT_EN with MD_TIMEOUT=8 and md_ready never asserted -> md_error=1 after 8 BUSY cycles, stalls release.
